serialize: RTL and testbench

- DTI stage that accepts one beat carrying NUM packed elements of W bits and emits them one per handshake, LSB element first.
- Each output beat carries an end-of-transaction flag in its MSB.
- Sits directly upstream of the decoupler: its dout feeds decoupler din, so the wide beat is spread over NUM cycles before buffering.

---
 rtl/serialize_pkg.sv | 23 ++
 rtl/serialize.sv | 86 ++++++++
 tb/tb_serialize.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serialize_pkg.sv
// rtl/serialize_pkg.sv - state type and sizing helpers for serialize; SERIALIZE_LEN_EN adds a length field to din
package serialize_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic int cnt_w(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

`ifdef SERIALIZE_LEN_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  function automatic int din_w(input int num, input int w);
    return num * w + (LEN_EN ? cnt_w(num) : 0);
  endfunction

endpackage

// File: rtl/serialize.sv
// rtl/serialize.sv - splits one NUM*W beat into NUM W-bit beats, LSB element first, eot in MSB (SERIALIZE_LEN_EN: per-beat length)
module serialize
  import serialize_pkg::*;
#(
  parameter  int NUM   = 4,
  parameter  int W     = 16,
  localparam int CW    = cnt_w(NUM),
  localparam int DIN_W = din_w(NUM, W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIN_W-1:0] din_data,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [W:0]       dout_data,
  output logic             dout_valid,
  input  logic             dout_ready
);

  localparam logic [CW-1:0] MAX_IDX = CW'(NUM - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NUM*W-1:0]  hold_q, hold_d;
  logic [CW-1:0]     last_idx;
  logic              busy;
  logic              eot;
  logic              take;

  assign busy = (state_q == BUSY);
  assign eot  = (cnt_q == last_idx);
  assign take = din_valid & din_ready;

  // dout_ready reaches din_ready combinationally so a new beat loads on the eot handshake without a bubble
  assign din_ready  = !busy | (eot & dout_ready);
  assign dout_valid = busy;
  assign dout_data  = {eot, hold_q[int'(cnt_q)*W +: W]};

`ifdef SERIALIZE_LEN_EN
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] len_field;

  assign len_field = din_data[NUM*W +: CW];
  assign len_d     = take ? ((len_field > MAX_IDX) ? MAX_IDX : len_field) : len_q;
  assign last_idx  = len_q;
`else
  assign last_idx  = MAX_IDX;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    if (take) begin
      hold_d  = din_data[NUM*W-1:0];
      cnt_d   = '0;
      state_d = BUSY;
    end else if (busy && dout_ready) begin
      if (eot) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Data path is only observed while busy, so it carries no reset
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
`ifdef SERIALIZE_LEN_EN
    len_q  <= len_d;
`endif
  end

endmodule

// File: tb/tb_serialize.sv
// tb/tb_serialize.sv - randomized scoreboard bench for serialize (NUM=4, W=8; honours SERIALIZE_LEN_EN)
module tb_serialize;

  localparam int NUM = 4;
  localparam int W   = 8;
  localparam int CW  = $clog2(NUM);
`ifdef SERIALIZE_LEN_EN
  localparam int DIN_W = NUM * W + CW;
`else
  localparam int DIN_W = NUM * W;
`endif

  typedef logic [DIN_W-1:0] word_t;
  typedef word_t word_q_t[$];

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [DIN_W-1:0] din_data = '0;
  logic             din_valid = 1'b0;
  logic             din_ready;
  logic [W:0]       dout_data;
  logic             dout_valid;
  logic             dout_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serialize #(.NUM(NUM), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_data   (din_data),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout_data  (dout_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  // Full-length word: under the length option the field is all ones, which saturates to NUM-1
  function automatic word_t mk(input logic [NUM*W-1:0] data);
    word_t wd;
    wd = '1;
    wd[NUM*W-1:0] = data;
    return wd;
  endfunction

  function automatic word_t rand_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DIN_W-1:0];
  endfunction

  // Scoreboard: each accepted word expands to its active elements in order, eot on the last one
  task automatic run_stream(input string name, input word_q_t words, input int p_valid, input int p_ready);
    logic [W:0] exp_q[$];
    logic [W:0] exp_b;
    logic [W:0] held;
    bit         stalled;
    bit         taken;
    int         sent;
    int         cyc;
    int         n;
    stalled = 0;
    taken   = 0;
    sent    = 0;
    cyc     = 0;
    held    = '0;
    while ((sent < words.size() || exp_q.size() != 0) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (taken) din_valid = 1'b0;
      taken = 0;
      if (!din_valid && sent < words.size() && $urandom_range(99) < p_valid) begin
        din_valid = 1'b1;
        din_data  = words[sent];
      end
      dout_ready = ($urandom_range(99) < p_ready);
      #1;
      tests++;
      if (dout_valid !== (exp_q.size() != 0)) begin
        fails++;
        $display("FAIL %s dout_valid: got %b, expected %b (cycle %0d)", name, dout_valid, exp_q.size() != 0, cyc);
      end
      if (stalled) begin
        tests++;
        if (dout_data !== held) begin
          fails++;
          $display("FAIL %s stall_stable: got %h, expected %h", name, dout_data, held);
        end
      end
      stalled = 0;
      if (dout_valid && exp_q.size() != 0) begin
        if (dout_ready) begin
          exp_b = exp_q.pop_front();
          tests++;
          if (dout_data !== exp_b) begin
            fails++;
            $display("FAIL %s beat_data: got %h, expected %h", name, dout_data, exp_b);
          end
        end else begin
          stalled = 1;
          held    = dout_data;
        end
      end
      if (din_valid && din_ready) begin
        n = NUM;
`ifdef SERIALIZE_LEN_EN
        begin
          int f;
          f = int'(words[sent][NUM*W +: CW]);
          n = ((f > NUM - 1) ? NUM - 1 : f) + 1;
        end
`endif
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), words[sent][i*W +: W]});
        sent++;
        taken = 1;
      end
    end
    if (cyc >= 4000) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: got %0d words sent, expected %0d", name, sent, words.size());
    end
    @(negedge clk);
    din_valid  = 1'b0;
    dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    tests++;
    if (dout_valid !== 1'b0) begin fails++; $display("FAIL reset dout_valid: got %b, expected 0", dout_valid); end
    tests++;
    if (din_ready !== 1'b1) begin fails++; $display("FAIL reset din_ready: got %b, expected 1", din_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      dout_ready = c[0];
      #1;
      tests++;
      if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
        fails++;
        $display("FAIL idle ready/valid: got %b/%b, expected 1/0", din_ready, dout_valid);
      end
    end
  endtask

  task automatic test_single();
    logic [W:0] exp_s[4];
    exp_s = '{9'h011, 9'h022, 9'h033, 9'h144};
    @(negedge clk);
    din_data   = mk(32'h44332211);
    din_valid  = 1'b1;
    dout_ready = 1'b1;
    #1;
    tests++;
    if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL single accept ready/valid: got %b/%b, expected 1/0", din_ready, dout_valid);
    end
    @(negedge clk);
    din_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      #1;
      tests++;
      if (dout_valid !== 1'b1 || dout_data !== exp_s[b]) begin
        fails++;
        $display("FAIL single beat%0d: got v=%b d=%h, expected v=1 d=%h", b, dout_valid, dout_data, exp_s[b]);
      end
      tests++;
      if (din_ready !== (b == 3)) begin
        fails++;
        $display("FAIL single din_ready beat%0d: got %b, expected %b", b, din_ready, b == 3);
      end
      @(negedge clk);
    end
    #1;
    tests++;
    if (dout_valid !== 1'b0) begin fails++; $display("FAIL single after_eot valid: got %b, expected 0", dout_valid); end
  endtask

  task automatic test_back_to_back();
    word_q_t w;
    w.push_back(mk(32'h44332211));
    w.push_back(mk(32'h88776655));
    for (int i = 0; i < 6; i++) w.push_back(mk(rand_word()));
    run_stream("back_to_back", w, 100, 100);
  endtask

  task automatic test_backpressure();
    word_q_t w;
    for (int i = 0; i < 25; i++) w.push_back(mk(rand_word()));
    run_stream("backpressure", w, 70, 50);
  endtask

  task automatic test_random_mix();
    word_q_t w;
    for (int i = 0; i < 40; i++) w.push_back(rand_word());
    run_stream("random_mix", w, 60, 75);
  endtask

  task automatic test_reset_mid();
    word_q_t w;
    @(negedge clk);
    din_data   = mk(32'hA4A3A2A1);
    din_valid  = 1'b1;
    dout_ready = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (dout_valid !== 1'b0) begin fails++; $display("FAIL reset_mid async valid: got %b, expected 0", dout_valid); end
    tests++;
    if (din_ready !== 1'b1) begin fails++; $display("FAIL reset_mid din_ready: got %b, expected 1", din_ready); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid release ready/valid: got %b/%b, expected 1/0", din_ready, dout_valid);
    end
    w.push_back(mk(32'hB4B3B2B1));
    run_stream("reset_mid_restart", w, 100, 100);
  endtask

`ifdef SERIALIZE_LEN_EN
  task automatic test_len();
    word_q_t w;
    word_t   x;
    x = '0;
    x[NUM*W-1:0]  = 32'hDDCCBBAA;
    x[NUM*W +: CW] = CW'(1);
    w.push_back(x);
    x[NUM*W +: CW] = CW'(0);
    w.push_back(x);
    x[NUM*W +: CW] = '1;
    w.push_back(x);
    for (int i = 0; i < 15; i++) w.push_back(rand_word());
    run_stream("len_field", w, 80, 80);
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef SERIALIZE_LEN_EN
    test_len();
`endif
    test_random_mix();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
